// File: rtl/ascii_pkg.sv
// ---------------------------------------------------------------------------
// ascii_pkg
// Shared definitions for the ASCII operand parser:
//   - ASCII code points recognised by the character classifier
//   - FSM state encoding used by the parser top level
// ---------------------------------------------------------------------------
package ascii_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_PLUS = 8'h2B;
  localparam logic [7:0] ASCII_EQ   = 8'h3D;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_SP   = 8'h20;

  // GET_A : collecting digits of the first operand
  // GET_B : collecting digits of the second operand
  // HOLD  : both operands presented downstream, waiting for ops_ready
  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/ascii_char_classify.sv
// ---------------------------------------------------------------------------
// ascii_char_classify
// Purely combinational classifier for one ASCII byte.
//
// Ports:
//   i_char      in   8  ASCII character
//   o_is_digit  out  1  '0'..'9'
//   o_is_plus   out  1  '+'
//   o_is_end    out  1  '=' or carriage return
//   o_is_space  out  1  ' '
//   o_digit_val out  4  numeric value of the digit (meaningful only when
//                       o_is_digit is set)
// ---------------------------------------------------------------------------
module ascii_char_classify
  import ascii_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_is_digit,
  output logic       o_is_plus,
  output logic       o_is_end,
  output logic       o_is_space,
  output logic [3:0] o_digit_val
);

  assign o_is_digit = (i_char >= ASCII_ZERO) && (i_char <= ASCII_NINE);
  assign o_is_plus  = (i_char == ASCII_PLUS);
  assign o_is_end   = (i_char == ASCII_EQ) || (i_char == ASCII_CR);
  assign o_is_space = (i_char == ASCII_SP);

  // '0'..'9' are 0x30..0x39, so the low nibble already is the digit value;
  // no subtractor is needed.
  assign o_digit_val = i_char[3:0];

endmodule

// File: rtl/ascii_operand_parser.sv
// ---------------------------------------------------------------------------
// ascii_operand_parser
// Parses an ASCII stream of the form <digits>+<digits>= (or CR as the
// terminator), converts both decimal operands to unsigned binary and hands
// them downstream over a valid/ready handshake. Spaces are ignored anywhere.
// Any malformed byte produces a one-cycle err pulse and restarts parsing.
//
// Parameters:
//   MAX_DIGITS  maximum decimal digits per operand
//   OP_W        operand width; must hold 10^MAX_DIGITS - 1
//
// Ports:
//   clk          in   1     rising-edge clock
//   rst_n        in   1     synchronous active-low reset
//   ascii_in     in   8     ASCII character
//   ascii_valid  in   1     ascii_in is valid this cycle
//   ascii_ready  out  1     parser accepts a character this cycle
//   op_a         out  OP_W  first operand
//   op_b         out  OP_W  second operand
//   ops_valid    out  1     op_a/op_b complete and stable
//   ops_ready    in   1     downstream consumes the operands
//   err          out  1     one-cycle malformed-expression pulse
// ---------------------------------------------------------------------------
module ascii_operand_parser
  import ascii_pkg::*;
#(
  parameter int MAX_DIGITS = 2,
  parameter int OP_W       = 7
)
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      ascii_in,
  input  logic            ascii_valid,
  output logic            ascii_ready,
  output logic [OP_W-1:0] op_a,
  output logic [OP_W-1:0] op_b,
  output logic            ops_valid,
  input  logic            ops_ready,
  output logic            err
);

  // Refuse to build a parser whose operand register cannot hold the largest
  // decimal value it may be asked to parse.
  if ((2 ** OP_W) <= ((10 ** MAX_DIGITS) - 1)) begin : g_width_check
    $error("ascii_operand_parser: OP_W too narrow for MAX_DIGITS");
  end

  localparam int                CNT_W   = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_DIGITS);

  // Multiply-by-ten via shifts, then add the new digit. Truncation to OP_W
  // is safe because the width check above bounds the result.
  function automatic logic [OP_W-1:0] acc_step(input logic [OP_W-1:0] acc,
                                               input logic [3:0]      val);
    return (acc << 3) + (acc << 1) + OP_W'(val);
  endfunction

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [OP_W-1:0]   r_op_a;
  logic [OP_W-1:0]   r_op_b;
  logic              r_ops_valid;
  logic              r_ascii_ready;
  logic              r_err;

  // -------------------------------------------------------------------------
  // Character classification
  // -------------------------------------------------------------------------
  logic       w_is_digit;
  logic       w_is_plus;
  logic       w_is_end;
  logic       w_is_space;
  logic [3:0] w_digit_val;

  ascii_char_classify u_classify (
    .i_char      (ascii_in),
    .o_is_digit  (w_is_digit),
    .o_is_plus   (w_is_plus),
    .o_is_end    (w_is_end),
    .o_is_space  (w_is_space),
    .o_digit_val (w_digit_val)
  );

  // -------------------------------------------------------------------------
  // Byte decode: decide what the accepted byte does in the current state.
  // -------------------------------------------------------------------------
  logic            w_accept;
  logic            w_room;
  logic            w_have_digit;
  logic            w_take_digit;
  logic            w_plus_ok;
  logic            w_end_ok;
  logic            w_error;
  logic [OP_W-1:0] w_base_a;
  logic [OP_W-1:0] w_base_b;

  // ascii_ready is registered, so acceptance never feeds back into it.
  assign w_accept     = ascii_valid && r_ascii_ready;
  assign w_room       = (r_cnt < CNT_MAX);
  assign w_have_digit = (r_cnt != '0);

  assign w_take_digit = w_accept && w_is_digit && w_room &&
                        ((r_state == GET_A) || (r_state == GET_B));
  assign w_plus_ok    = w_accept && w_is_plus && w_have_digit && (r_state == GET_A);
  assign w_end_ok     = w_accept && w_is_end  && w_have_digit && (r_state == GET_B);

  // Anything accepted that is neither a space nor one of the legal moves
  // above is malformed: excess digits, misplaced '+'/'=', or unknown bytes.
  assign w_error      = w_accept && !w_is_space &&
                        !(w_take_digit || w_plus_ok || w_end_ok);

  // The first digit of an operand starts from zero, so values left over from
  // the previous expression are discarded without a separate clear cycle.
  assign w_base_a = w_have_digit ? r_op_a : '0;
  assign w_base_b = w_have_digit ? r_op_b : '0;

  // -------------------------------------------------------------------------
  // FSM, accumulators and registered outputs
  // -------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= GET_A;
      r_cnt         <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_ops_valid   <= 1'b0;
      r_ascii_ready <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      // NOTE: err defaults low every cycle so that setting it below yields a
      // pulse exactly one cycle long.
      r_err <= 1'b0;

      if (w_error) begin
        // The offending byte is consumed; parsing restarts cleanly.
        r_err         <= 1'b1;
        r_state       <= GET_A;
        r_cnt         <= '0;
        r_op_a        <= '0;
        r_op_b        <= '0;
        r_ops_valid   <= 1'b0;
        r_ascii_ready <= 1'b1;
      end else begin
        unique case (r_state)
          GET_A: begin
            r_ascii_ready <= 1'b1;
            if (w_take_digit) begin
              r_op_a <= acc_step(w_base_a, w_digit_val);
              r_cnt  <= r_cnt + 1'b1;
            end else if (w_plus_ok) begin
              r_state <= GET_B;
              r_cnt   <= '0;
            end
          end

          GET_B: begin
            r_ascii_ready <= 1'b1;
            if (w_take_digit) begin
              r_op_b <= acc_step(w_base_b, w_digit_val);
              r_cnt  <= r_cnt + 1'b1;
            end else if (w_end_ok) begin
              // ascii_ready falls in the same cycle ops_valid rises.
              r_state       <= HOLD;
              r_cnt         <= '0;
              r_ops_valid   <= 1'b1;
              r_ascii_ready <= 1'b0;
            end
          end

          HOLD: begin
            // Operands stay put until the downstream handshake completes;
            // they are only cleared by the next expression's first digit.
            if (r_ops_valid && ops_ready) begin
              r_state       <= GET_A;
              r_ops_valid   <= 1'b0;
              r_ascii_ready <= 1'b1;
            end
          end

          default: begin
            r_state       <= GET_A;
            r_cnt         <= '0;
            r_ops_valid   <= 1'b0;
            r_ascii_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ascii_ready = r_ascii_ready;
  assign op_a        = r_op_a;
  assign op_b        = r_op_b;
  assign ops_valid   = r_ops_valid;
  assign err         = r_err;

endmodule

// File: tb/tb_ascii_operand_parser.sv
// ---------------------------------------------------------------------------
// tb_ascii_operand_parser
// Directed self-checking bench for ascii_operand_parser. Expected operand
// pairs are queued when an expression is driven and compared when the DUT
// completes the downstream handshake.
// ---------------------------------------------------------------------------
module tb_ascii_operand_parser;

  localparam int OP_W = 7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      ascii_in = 8'h00;
  logic            ascii_valid = 1'b0;
  logic            ascii_ready;
  logic [OP_W-1:0] op_a;
  logic [OP_W-1:0] op_b;
  logic            ops_valid;
  logic            ops_ready = 1'b0;
  logic            err;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } exp_t;

  exp_t sb[$];
  exp_t mon_exp;
  int   total    = 0;
  int   bad      = 0;
  int   err_seen = 0;
  int   err_mark = 0;

  always #5 clk = ~clk;

  ascii_operand_parser #(.MAX_DIGITS(2), .OP_W(OP_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ascii_in    (ascii_in),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .ops_valid   (ops_valid),
    .ops_ready   (ops_ready),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Output monitor: samples on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err) err_seen++;
      if (ops_valid && ops_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ops_valid", ops_valid, 1'b0);
        end else begin
          mon_exp = sb.pop_front();
          check("sb_op_a", op_a, mon_exp.a);
          check("sb_op_b", op_b, mon_exp.b);
        end
      end
    end
  end

  // Present one byte and hold it until accepted; returns #1 after the
  // accepting edge with ascii_valid still high.
  task automatic send(input logic [7:0] c);
    int n = 0;
    ascii_in    = c;
    ascii_valid = 1'b1;
    @(negedge clk);
    while (!ascii_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ascii_ready) check("send_timeout_ready", ascii_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Random idle gap (with junk on the bus) before the byte.
  task automatic send_gap(input logic [7:0] c);
    int g = $urandom_range(0, 2);
    for (int i = 0; i < g; i++) begin
      ascii_valid = 1'b0;
      ascii_in    = 8'($urandom);
      @(posedge clk);
      #1;
    end
    send(c);
  endtask

  task automatic idle(input int n);
    ascii_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    ascii_valid = 1'b0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic push(input int a, input int b);
    sb.push_back(exp_t'{a: OP_W'(a), b: OP_W'(b)});
  endtask

  // Malformed case: legal prefix, then the byte that must raise err, then
  // a clean expression to prove recovery.
  task automatic err_case(input string tag, input string prefix,
                          input logic [7:0] bad_c);
    send_str(prefix);
    check({tag, "_no_early_err"}, err, 1'b0);
    send(bad_c);
    check({tag, "_err"}, err, 1'b1);
    idle(1);
    check({tag, "_err_one_cycle"}, err, 1'b0);
    push(1, 1);
    send_str("1+1=");
    drain({tag, "_recover"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_ops_valid", ops_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ascii_ready", ascii_ready, 1'b0);
    rst_n = 1'b1;

    // ---------------- 1: basic parse ----------------
    ops_ready = 1'b1;
    push(47, 25);
    send_str("47+25");
    check("t1_valid_before_eq", ops_valid, 1'b0);
    send("=");
    check("t1_valid_latency", ops_valid, 1'b1);
    check("t1_ready_low", ascii_ready, 1'b0);
    check("t1_no_err", err, 1'b0);
    drain("t1_drain");

    // ---------------- 2: backpressure ----------------
    ops_ready = 1'b0;
    push(9, 9);
    send_str("9+9");
    send(8'h0D);
    ascii_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_hold_valid", ops_valid, 1'b1);
      check("t2_hold_ready", ascii_ready, 1'b0);
      check("t2_hold_op_a", op_a, 9);
      check("t2_hold_op_b", op_b, 9);
    end
    @(posedge clk);
    #1;
    ops_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t2_ready_back", ascii_ready, 1'b1);
    check("t2_valid_drop", ops_valid, 1'b0);
    drain("t2_drain");

    // ---------------- 3: malformed input ----------------
    err_mark = err_seen;
    err_case("t3_excess_digit", "12", "3");
    err_case("t3_plus_first", "", "+");
    err_case("t3_empty_b", "5+", "=");
    err_case("t3_invalid", "5", "x");
    check("t3_err_count", err_seen - err_mark, 4);

    // ---------------- 4: spaces and gaps ----------------
    err_mark = err_seen;
    push(3, 8);
    send_gap(" ");
    send_gap("3");
    send_gap(" ");
    send_gap(" ");
    send_gap("+");
    send_gap(" ");
    send_gap("8");
    send_gap("=");
    drain("t4_drain");
    check("t4_no_err", err_seen - err_mark, 0);

    // ---------------- 5: reset mid-operation ----------------
    send_str("6+");
    ascii_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t5_op_a", op_a, 0);
    check("t5_op_b", op_b, 0);
    check("t5_ops_valid", ops_valid, 1'b0);
    check("t5_err", err, 1'b0);
    check("t5_ascii_ready", ascii_ready, 1'b0);
    rst_n = 1'b1;
    push(0, 0);
    send_str("0+0=");
    drain("t5_drain");

    // reset while holding: the pending pair is discarded
    ops_ready = 1'b0;
    send_str("9+9=");
    idle(2);
    check("t5_hold_valid", ops_valid, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t5_hold_reset_valid", ops_valid, 1'b0);
    rst_n = 1'b1;
    ops_ready = 1'b1;
    idle(3);
    check("t5_hold_stays_idle", ops_valid, 1'b0);
    check("t5_hold_ready", ascii_ready, 1'b1);

    // ---------------- 6: upper bound, back-to-back ----------------
    err_mark = err_seen;
    push(99, 99);
    push(99, 99);
    send_str("99+99=99+99=");
    drain("t6_drain");
    check("t6_no_err", err_seen - err_mark, 0);
    check("t6_final_op_a", op_a, 7'h63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
